// File: rtl/dmem_port_arbiter_if.sv
// Bundles both requester ports and the data-memory side of the arbiter.
// Latency: none, wiring only.
// Backpressure: requesters hold req and command stable until they see gnt.
interface dmem_port_arbiter_if #(
    parameter int AW = 32
);
    localparam int DW = 32;

    // port 0: core load/store unit
    logic          p0_req;
    logic          p0_we;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic [3:0]    p0_be;
    logic          p0_gnt;
    logic          p0_rvalid;
    logic [DW-1:0] p0_rdata;

    // port 1: DMA / debug loader
    logic          p1_req;
    logic          p1_we;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic [3:0]    p1_be;
    logic          p1_gnt;
    logic          p1_rvalid;
    logic [DW-1:0] p1_rdata;

    // single-port word memory
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;

    // arbiter view
    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata, p0_be,
        output p0_gnt, p0_rvalid, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_wdata, p1_be,
        output p1_gnt, p1_rvalid, p1_rdata,
        output mem_we, mem_be, mem_addr, mem_wd,
        input  mem_rd
    );

    // requester + memory view (environment side)
    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata, p0_be,
        input  p0_gnt, p0_rvalid, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_wdata, p1_be,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  mem_we, mem_be, mem_addr, mem_wd,
        output mem_rd
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter for the single-port dmem (port 0 = LSU, port 1 = DMA/debug); DMEM_ARB_RR_EN selects round-robin.
// Latency: grant and mem command combinational in the request cycle; load data returned the next cycle.
// Backpressure: a denied requester holds its command; port 1 is forced through after STARVE_LIMIT denials.
module dmem_port_arbiter #(
    parameter int AW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    dmem_port_arbiter_if.slave bus
);
    localparam int DW = 32;
    localparam logic [AW-1:0] WORD_MASK = ~AW'(3);

    // ARB_P1 means port 1 wins a contended cycle (forced in fixed mode, its turn in RR mode)
    typedef enum logic {
        ARB_P0 = 1'b0,
        ARB_P1 = 1'b1
    } arb_state_t;

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic          gnt0;
    logic          gnt1;

    logic          cmd_we;
    logic [3:0]    cmd_be;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wd;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wd_q;

    logic          rsp_pend;
    logic          rsp_port;

`ifndef DMEM_ARB_RR_EN
    logic [3:0]    starve_cnt;
`endif

    // arbitration state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_P0;
        end else begin
            state <= state_nxt;
        end
    end

    // next arbitration state
    always_comb begin
        state_nxt = state;
`ifdef DMEM_ARB_RR_EN
        // the port just served drops to lower priority
        if (gnt0) begin
            state_nxt = ARB_P1;
        end else if (gnt1) begin
            state_nxt = ARB_P0;
        end
`else
        case (state)
            ARB_P0: begin
                if (bus.p1_req && gnt0 && (starve_cnt == 4'(STARVE_LIMIT - 1))) begin
                    state_nxt = ARB_P1;
                end
            end
            default: begin
                // forced slot lasts one cycle whether or not port 1 used it
                state_nxt = ARB_P0;
            end
        endcase
`endif
    end

    // grant decode: the favoured port wins, the other takes an idle slot
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state)
            ARB_P0: begin
                if (bus.p0_req) begin
                    gnt0 = 1'b1;
                end else if (bus.p1_req) begin
                    gnt1 = 1'b1;
                end
            end
            default: begin
                if (bus.p1_req) begin
                    gnt1 = 1'b1;
                end else if (bus.p0_req) begin
                    gnt0 = 1'b1;
                end
            end
        endcase
    end

`ifndef DMEM_ARB_RR_EN
    // count consecutive port-1 denials; any port-1 grant or forced slot restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
        end else if (gnt1 || (state == ARB_P1)) begin
            starve_cnt <= 4'd0;
        end else if (bus.p1_req && gnt0) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`endif

    // mux the granted command onto the memory; address/data hold when idle
    always_comb begin
        cmd_we   = 1'b0;
        cmd_be   = 4'b0000;
        cmd_addr = addr_q;
        cmd_wd   = wd_q;
        if (gnt0) begin
            cmd_we   = bus.p0_we;
            cmd_be   = bus.p0_we ? bus.p0_be : 4'b0000;
            cmd_addr = bus.p0_addr & WORD_MASK;
            cmd_wd   = bus.p0_wdata;
        end else if (gnt1) begin
            cmd_we   = bus.p1_we;
            cmd_be   = bus.p1_we ? bus.p1_be : 4'b0000;
            cmd_addr = bus.p1_addr & WORD_MASK;
            cmd_wd   = bus.p1_wdata;
        end
    end

    // remember the last driven address/data so the bus stays quiet when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            wd_q   <= '0;
        end else if (gnt0 || gnt1) begin
            addr_q <= cmd_addr;
            wd_q   <= cmd_wd;
        end
    end

    // track which port owns the read data arriving next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_pend <= 1'b0;
            rsp_port <= 1'b0;
        end else begin
            rsp_pend <= (gnt0 && !bus.p0_we) || (gnt1 && !bus.p1_we);
            if ((gnt0 && !bus.p0_we) || (gnt1 && !bus.p1_we)) begin
                rsp_port <= gnt1;
            end
        end
    end

    // drive grants, memory command and the steered read response
    always_comb begin
        bus.p0_gnt    = gnt0;
        bus.p1_gnt    = gnt1;
        bus.mem_we    = cmd_we;
        bus.mem_be    = cmd_be;
        bus.mem_addr  = cmd_addr;
        bus.mem_wd    = cmd_wd;
        bus.p0_rvalid = rsp_pend && !rsp_port;
        bus.p1_rvalid = rsp_pend && rsp_port;
        bus.p0_rdata  = (rsp_pend && !rsp_port) ? bus.mem_rd : '0;
        bus.p1_rdata  = (rsp_pend && rsp_port) ? bus.mem_rd : '0;
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;
    localparam int AW    = 32;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.AW(AW)) bus ();

    dmem_port_arbiter #(.AW(AW), .STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // environment memory: write-first, one-cycle synchronous read
    logic [31:0] env_mem [0:63];
    always @(posedge clk) begin
        if (bus.mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_be[b]) env_mem[bus.mem_addr[7:2]][8*b +: 8] = bus.mem_wd[8*b +: 8];
            end
        end
        bus.mem_rd <= env_mem[bus.mem_addr[7:2]];
    end

    // reference model state: expected memory contents, pending response, fairness state
    logic [31:0] mdl_mem [0:63];
    logic        m_pend;
    logic        m_pport;
    logic [31:0] m_pdata;
    int          m_deny;
    logic        m_rr_last;
    logic [31:0] m_last_addr;
    logic [31:0] m_last_wd;

    initial begin
        for (int i = 0; i < 64; i++) begin
            env_mem[i] = 32'hA500_0000 | i;
            mdl_mem[i] = 32'hA500_0000 | i;
        end
        env_mem[4] = 32'hDEADBEEF; mdl_mem[4] = 32'hDEADBEEF;
        env_mem[8] = 32'h11223344; mdl_mem[8] = 32'h11223344;
    end

    // per-cycle comparison against the model, sampled mid-cycle
    always @(negedge clk) begin
        logic        p1_first, e_g0, e_g1, e_we, w;
        logic [3:0]  e_be;
        logic [31:0] a, d, e_addr, e_wd;
        logic [3:0]  be;
        if (!rst_n) begin
            m_pend = 1'b0; m_pport = 1'b0; m_pdata = '0; m_deny = 0;
            m_rr_last = 1'b1; m_last_addr = '0; m_last_wd = '0;
            chk("reset_p0_gnt", 32'(bus.p0_gnt), 0);
            chk("reset_p1_gnt", 32'(bus.p1_gnt), 0);
            chk("reset_p0_rvalid", 32'(bus.p0_rvalid), 0);
            chk("reset_p1_rvalid", 32'(bus.p1_rvalid), 0);
            chk("reset_p0_rdata", bus.p0_rdata, 0);
            chk("reset_p1_rdata", bus.p1_rdata, 0);
            chk("reset_mem_we", 32'(bus.mem_we), 0);
            chk("reset_mem_be", 32'(bus.mem_be), 0);
            chk("reset_mem_addr", bus.mem_addr, 0);
            chk("reset_mem_wd", bus.mem_wd, 0);
        end else begin
`ifdef DMEM_ARB_RR_EN
            p1_first = (m_rr_last == 1'b0);
`else
            p1_first = (m_deny >= LIMIT);
`endif
            e_g1 = bus.p1_req && (p1_first || !bus.p0_req);
            e_g0 = bus.p0_req && !e_g1;
            a = e_g1 ? bus.p1_addr : bus.p0_addr;
            d = e_g1 ? bus.p1_wdata : bus.p0_wdata;
            w = e_g1 ? bus.p1_we : bus.p0_we;
            be = e_g1 ? bus.p1_be : bus.p0_be;
            e_we = (e_g0 || e_g1) && w;
            e_be = e_we ? be : 4'b0000;
            e_addr = (e_g0 || e_g1) ? {a[31:2], 2'b00} : m_last_addr;
            e_wd = (e_g0 || e_g1) ? d : m_last_wd;

            chk("p0_gnt", 32'(bus.p0_gnt), 32'(e_g0));
            chk("p1_gnt", 32'(bus.p1_gnt), 32'(e_g1));
            chk("mem_we", 32'(bus.mem_we), 32'(e_we));
            chk("mem_be", 32'(bus.mem_be), 32'(e_be));
            chk("mem_addr", bus.mem_addr, e_addr);
            chk("mem_wd", bus.mem_wd, e_wd);
            chk("p0_rvalid", 32'(bus.p0_rvalid), 32'(m_pend && !m_pport));
            chk("p1_rvalid", 32'(bus.p1_rvalid), 32'(m_pend && m_pport));
            chk("p0_rdata", bus.p0_rdata, (m_pend && !m_pport) ? m_pdata : 32'h0);
            chk("p1_rdata", bus.p1_rdata, (m_pend && m_pport) ? m_pdata : 32'h0);
            chk("rvalid_exclusive", 32'(bus.p0_rvalid && bus.p1_rvalid), 0);

            // advance the model to the state after this cycle's clock edge
            m_last_addr = e_addr;
            m_last_wd = e_wd;
            m_pend = 1'b0;
            if (e_g0 || e_g1) begin
                if (w) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[b]) mdl_mem[a[7:2]][8*b +: 8] = d[8*b +: 8];
                    end
                end else begin
                    m_pend = 1'b1;
                    m_pport = e_g1;
                    m_pdata = mdl_mem[a[7:2]];
                end
            end
`ifdef DMEM_ARB_RR_EN
            if (e_g0) m_rr_last = 1'b0;
            else if (e_g1) m_rr_last = 1'b1;
`else
            if (e_g1 || m_deny >= LIMIT) m_deny = 0;
            else if (bus.p1_req) m_deny++;
`endif
        end
    end

    logic cap_g0, cap_g1;

    task automatic idle();
        bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0; bus.p0_be = '0;
        bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0; bus.p1_be = '0;
    endtask

    // one clock of stimulus; grants are captured mid-cycle, inputs return to idle after
    task automatic step(input logic r0, input logic we0, input logic [31:0] a0, input logic [31:0] wd0,
                        input logic [3:0] be0, input logic r1, input logic we1, input logic [31:0] a1,
                        input logic [31:0] wd1, input logic [3:0] be1);
        bus.p0_req = r0; bus.p0_we = we0; bus.p0_addr = a0; bus.p0_wdata = wd0; bus.p0_be = be0;
        bus.p1_req = r1; bus.p1_we = we1; bus.p1_addr = a1; bus.p1_wdata = wd1; bus.p1_be = be1;
        #1;
        cap_g0 = bus.p0_gnt;
        cap_g1 = bus.p1_gnt;
        @(posedge clk);
        #1;
        idle();
    endtask

    logic [9:0] seq10;
    logic [4:0] seq5;

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // 1: simple port-0 load
        step(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0);
        chk("t1_gnt", 32'(cap_g0), 1);
        chk("t1_rvalid", 32'(bus.p0_rvalid), 1);
        chk("t1_rdata", bus.p0_rdata, 32'hDEADBEEF);

        // 2: byte store, empty-strobe store, port-1 half store, read back
        step(1, 1, 32'h22, 32'h000000AB, 4'b0001, 0, 0, 0, 0, 0);
        step(1, 0, 32'h20, 0, 0, 0, 0, 0, 0, 0);
        chk("t2_rdata_byte0", bus.p0_rdata, 32'h112233AB);
        step(1, 1, 32'h20, 32'hFFFFFFFF, 4'b0000, 0, 0, 0, 0, 0);
        chk("t2_be0_gnt", 32'(cap_g0), 1);
        step(0, 0, 0, 0, 0, 1, 1, 32'h21, 32'hCAFE0000, 4'b1100);
        step(1, 0, 32'h23, 0, 0, 0, 0, 0, 0, 0);
        chk("t2_rdata_merge", bus.p0_rdata, 32'hCAFE33AB);

        // 4: p1 load then p0 load back to back
        step(0, 0, 0, 0, 0, 1, 0, 32'h24, 0, 0);
        chk("t4_p1_rvalid", 32'(bus.p1_rvalid), 1);
        chk("t4_p1_rdata", bus.p1_rdata, 32'hA5000009);
        step(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0);
        chk("t4_p0_rvalid", 32'(bus.p0_rvalid), 1);
        chk("t4_p1_quiet", 32'(bus.p1_rvalid), 0);
        chk("t4_p0_rdata", bus.p0_rdata, 32'hDEADBEEF);

        // 3: both ports request every cycle (last grant was port 0, so give port 1 one first)
        step(0, 0, 0, 0, 0, 1, 0, 32'h24, 0, 0);
`ifdef DMEM_ARB_RR_EN
        seq10 = 10'b10_1010_1010;
`else
        seq10 = 10'b10_0001_0000;
`endif
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 32'h10, 0, 0, 1, 0, 32'h24, 0, 0);
            chk("t3_p1_gnt_seq", 32'(cap_g1), 32'(seq10[i]));
            chk("t3_p0_gnt_seq", 32'(cap_g0), 32'(!seq10[i]));
        end

        // 5: reset right after a load grant discards the response
        step(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("t5_rvalid_in_reset", 32'(bus.p0_rvalid), 0);
        chk("t5_rdata_in_reset", bus.p0_rdata, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t5_no_rvalid_after", 32'(bus.p0_rvalid), 0);
        chk("t5_mem_addr_after", bus.mem_addr, 0);

`ifndef DMEM_ARB_RR_EN
        // 6: port 1 drops its request in the forced slot; counter must restart
        for (int i = 0; i < LIMIT; i++) begin
            step(1, 0, 32'h10, 0, 0, 1, 0, 32'h24, 0, 0);
            chk("t6_denied", 32'(cap_g1), 0);
        end
        step(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0);
        chk("t6_p0_in_forced_slot", 32'(cap_g0), 1);
        seq5 = 5'b10000;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 32'h10, 0, 0, 1, 0, 32'h24, 0, 0);
            chk("t6_p1_gnt_seq", 32'(cap_g1), 32'(seq5[i]));
        end
`else
        seq5 = 5'b01010;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 32'h10, 0, 0, 1, 0, 32'h24, 0, 0);
            chk("t6_rr_p1_gnt_seq", 32'(cap_g1), 32'(seq5[i]));
        end
`endif

        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
